actbuf_pingpong_wr: RTL and testbench
=====================================

ACTBUF_PINGPONG_WR -- requirements
Module: actbuf_pingpong_wr

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, meaning bits per activation lane.
REQ-002 SHALL have parameter LANES, default 2, meaning activation lanes per write beat.
REQ-003 SHALL have parameter DEPTH, default 128, meaning beats per bank; a power of two, at least 4.
REQ-004 SHALL have port clk_h, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port temp_param_en, input, 1 bit: configuration load strobe.
REQ-007 SHALL have port cfg_words, input, $clog2(DEPTH)+1 bits: beats per tile.
REQ-008 SHALL have port cfg_tiles, input, 16 bits: tiles per run.
REQ-009 SHALL have port cfg_pingpong, input, 1 bit: 1 selects two banks, 0 selects bank 0 only.
REQ-010 SHALL have port actbuf_wr_req, output, 1 bit: producer may send the next beat.
REQ-011 SHALL have port actbuf_wr_vld, input, 1 bit: write beat valid.
REQ-012 SHALL have port actbuf_wr_data, input, LANES*DATA_LEN bits: write beat.
REQ-013 SHALL have port rd_en, input, 1 bit: consumer read strobe.
REQ-014 SHALL have port rd_addr, input, $clog2(DEPTH) bits: read beat index.
REQ-015 SHALL have port rd_data, output, LANES*DATA_LEN bits: read data.
REQ-016 SHALL have port rd_done, input, 1 bit: consumer releases the current read bank.
REQ-017 SHALL have port rd_bank_vld, output, 1 bit: the read bank holds a full tile.
REQ-018 SHALL have port sblk_status, output, 1 bit: one-cycle pulse when a tile completes.
REQ-019 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-020 SHALL have port err, output, 2 bits: sticky error flags; bit0 overflow/underflow, bit1 configuration.

Function
REQ-021 SHALL implement the states IDLE, FILL and WAIT_BANK.
REQ-022 SHALL act on temp_param_en only in IDLE.
REQ-023 SHALL, on a valid configuration load (cfg_words in 1..DEPTH and cfg_tiles ≥ 1), latch the configuration, clear the write count and tile count, and go to FILL the next cycle.
REQ-024 SHALL, on an invalid configuration load, set err[1] and stay in IDLE.
REQ-025 SHALL ignore temp_param_en outside IDLE, with no error.
REQ-026 SHALL drive actbuf_wr_req combinationally as (state==FILL) && (remaining > actbuf_wr_vld), where remaining = cfg_words − wr_cnt; this tolerates a producer that responds one cycle after seeing req.
REQ-027 SHALL, in FILL with vld=1, write actbuf_wr_data to wr_bank at address wr_cnt, then increment wr_cnt.
REQ-028 SHALL, on the beat where wr_cnt reaches cfg_words: set full[wr_bank]; pulse sblk_status in the next cycle; clear wr_cnt; increment the tile count; toggle wr_bank when cfg_pingpong=1.
REQ-029 SHALL, after REQ-028: go to IDLE and drop busy when the tile count equals cfg_tiles; otherwise go to WAIT_BANK if full[new wr_bank] is set, else stay in FILL.
REQ-030 SHALL treat vld=1 while not in FILL as overflow: data dropped, err[0] set.
REQ-031 SHALL leave WAIT_BANK for FILL in the cycle after full[wr_bank] clears.
REQ-032 SHALL return rd_data as bank[rd_bank][rd_addr] registered, with one-cycle latency; rd_data holds its value when rd_en=0.
REQ-033 SHALL drive rd_bank_vld = full[rd_bank].
REQ-034 SHALL, on rd_done with full[rd_bank]=1, clear full[rd_bank] and toggle rd_bank when pingpong.
REQ-035 SHALL, on rd_done with full[rd_bank]=0, ignore the strobe and set err[0] (underflow).
REQ-036 SHALL, when rd_done and a tile completion fall in the same cycle, apply both; the completion sees the cleared flag, so no WAIT_BANK is entered if the cleared bank becomes the new wr_bank.
REQ-037 SHALL support reads in IDLE after the run ends until all banks are released; a new configuration load does not clear full flags.
REQ-038 SHALL hold err until reset.

Reset
REQ-039 SHALL, on rst_n=0 at a clock edge, enter IDLE with wr_cnt=0, tile count=0, wr_bank=rd_bank=0, full flags=0, err=0, sblk_status=0, busy=0, actbuf_wr_req=0 and rd_data=0.
REQ-040 SHALL leave bank memory contents undefined after reset.
REQ-041 SHALL let reset asserted mid-run abort the run with no sblk_status pulse.

Verification
REQ-042 SHALL cover: load cfg_words=4, cfg_tiles=1, pingpong=1; vld every cycle while req -> exactly 4 writes, req low on the 4th beat, one sblk_status pulse, rd_bank_vld=1, busy=0.
REQ-043 SHALL cover: cfg_words=27, cfg_tiles=3, pingpong=1, no rd_done -> tiles 0 and 1 fill banks 0/1, then WAIT_BANK with req=0; rd_done -> FILL resumes into bank 0, 3rd pulse, IDLE.
REQ-044 SHALL cover: producer stalls of 5 cycles every 27 beats with cfg_words=120 -> 120 beats stored in order; rd_addr 0..119 returns the beats in order at 1-cycle latency.
REQ-045 SHALL cover: vld held one extra cycle after the final beat -> beat dropped and err=2'b01; a spurious rd_done -> err[0] stays set and flags are unchanged.
REQ-046 SHALL cover: cfg_words=0 -> err[1]=1 and IDLE; cfg_words=DEPTH with pingpong=0 -> wr_bank stays 0 and WAIT_BANK until each rd_done.
REQ-047 SHALL cover: rst_n low for one cycle after 10 beats -> all outputs at reset values the next cycle and no sblk_status pulse.

Source files
------------

// File: rtl/actbuf_pingpong_wr.sv
// Ping-pong activation buffer write side: fills one or two banks tile by tile
// from a req/vld producer and hands full banks to a consumer that reads and releases them.
module actbuf_pingpong_wr #(
    parameter int unsigned DATA_LEN = 16,
    parameter int unsigned LANES    = 2,
    parameter int unsigned DEPTH    = 128
) (
    input  logic                          clk_h,
    input  logic                          rst_n,
    input  logic                          temp_param_en,
    input  logic [$clog2(DEPTH):0]        cfg_words,
    input  logic [15:0]                   cfg_tiles,
    input  logic                          cfg_pingpong,
    output logic                          actbuf_wr_req,
    input  logic                          actbuf_wr_vld,
    input  logic [LANES*DATA_LEN-1:0]     actbuf_wr_data,
    input  logic                          rd_en,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [LANES*DATA_LEN-1:0]     rd_data,
    input  logic                          rd_done,
    output logic                          rd_bank_vld,
    output logic                          sblk_status,
    output logic                          busy,
    output logic [1:0]                    err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned W  = LANES * DATA_LEN;

    typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cfg_words_q;
    logic [15:0]     cfg_tiles_q;
    logic            cfg_pp_q;
    logic [CW-1:0]   wr_cnt_q;
    logic [15:0]     tile_cnt_q;
    logic            wr_bank_q;
    logic            rd_bank_q;
    logic [1:0]      full_q, full_d;
    logic [W-1:0]    mem [0:1][0:DEPTH-1];

    logic [CW-1:0]   remaining;
    logic            wr_fire, last_beat, tile_last, wr_bank_new;
    logic            cfg_load, cfg_ok, rd_rel, ovf, udf;

    // Next-state and write-side decode
    always_comb begin
        state_d     = state_q;
        remaining   = cfg_words_q - wr_cnt_q;
        wr_fire     = (state_q == FILL) && actbuf_wr_vld;
        last_beat   = wr_fire && ((wr_cnt_q + CW'(1)) == cfg_words_q);
        tile_last   = (tile_cnt_q + 16'd1) == cfg_tiles_q;
        wr_bank_new = cfg_pp_q ? ~wr_bank_q : wr_bank_q;
        cfg_load    = (state_q == IDLE) && temp_param_en;
        cfg_ok      = (cfg_words != '0) && (cfg_words <= CW'(DEPTH)) && (cfg_tiles != '0);
        rd_rel      = rd_done && full_q[rd_bank_q];
        ovf         = actbuf_wr_vld && (state_q != FILL);
        udf         = rd_done && !full_q[rd_bank_q];
        full_d      = full_q;
        // Release first so a same-cycle completion sees the cleared flag
        if (rd_rel)
            full_d[rd_bank_q] = 1'b0;
        if (last_beat)
            full_d[wr_bank_q] = 1'b1;
        actbuf_wr_req = (state_q == FILL) && (remaining > CW'(actbuf_wr_vld));
        case (state_q)
            IDLE: begin
                if (cfg_load && cfg_ok)
                    state_d = FILL;
            end
            FILL: begin
                if (last_beat) begin
                    if (tile_last)
                        state_d = IDLE;
                    else if (full_d[wr_bank_new])
                        state_d = WAIT_BANK;
                end
            end
            WAIT_BANK: begin
                if (!full_q[wr_bank_q])
                    state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Counters, bank pointers, flags and read port
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            cfg_words_q <= '0;
            cfg_tiles_q <= '0;
            cfg_pp_q    <= 1'b0;
            wr_cnt_q    <= '0;
            tile_cnt_q  <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            err         <= '0;
            sblk_status <= 1'b0;
            busy        <= 1'b0;
            rd_data     <= '0;
        end else begin
            sblk_status <= last_beat;
            busy        <= (state_d != IDLE);
            full_q      <= full_d;
            err         <= err | {cfg_load && !cfg_ok, ovf || udf};
            if (cfg_load && cfg_ok) begin
                cfg_words_q <= cfg_words;
                cfg_tiles_q <= cfg_tiles;
                cfg_pp_q    <= cfg_pingpong;
                wr_cnt_q    <= '0;
                tile_cnt_q  <= '0;
            end
            if (wr_fire) begin
                if (last_beat) begin
                    wr_cnt_q   <= '0;
                    tile_cnt_q <= tile_cnt_q + 16'd1;
                    wr_bank_q  <= wr_bank_new;
                end else begin
                    wr_cnt_q   <= wr_cnt_q + CW'(1);
                end
            end
            if (rd_rel && cfg_pp_q)
                rd_bank_q <= ~rd_bank_q;
            if (rd_en)
                rd_data <= mem[rd_bank_q][rd_addr];
        end
    end

    // Bank storage carries no reset
    always_ff @(posedge clk_h) begin
        if (rst_n && wr_fire)
            mem[wr_bank_q][wr_cnt_q[AW-1:0]] <= actbuf_wr_data;
    end

    assign rd_bank_vld = full_q[rd_bank_q];

endmodule

// File: tb/tb_actbuf_pingpong_wr.sv
// Directed bench for actbuf_pingpong_wr: a producer that answers req one cycle late,
// hand-computed read-back data, flags and pulse counts.
module tb_actbuf_pingpong_wr;

    logic        clk_h = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  cw;
    logic [15:0] ct;
    logic        pp;
    logic        req;
    logic        vld;
    logic [31:0] wdata;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        rd_bank_vld;
    logic        sblk;
    logic        busy;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;
    int pbase;
    bit rq_last;

    always #5 clk_h = ~clk_h;

    actbuf_pingpong_wr #(.DATA_LEN(16), .LANES(2), .DEPTH(128)) dut (
        .clk_h(clk_h), .rst_n(rst_n), .temp_param_en(en), .cfg_words(cw),
        .cfg_tiles(ct), .cfg_pingpong(pp), .actbuf_wr_req(req), .actbuf_wr_vld(vld),
        .actbuf_wr_data(wdata), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_done(rd_done), .rd_bank_vld(rd_bank_vld), .sblk_status(sblk),
        .busy(busy), .err(err)
    );

    always @(negedge clk_h)
        if (sblk === 1'b1) pulse_total++;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_h);
        rst_n = 1'b0; en = 1'b0; vld = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
        wdata = '0; rd_addr = '0; cw = '0; ct = '0; pp = 1'b0;
        repeat (2) @(negedge clk_h);
        rst_n = 1'b1;
    endtask

    task automatic load(input int words, input int tiles, input bit pingpong);
        @(negedge clk_h);
        en = 1'b1; cw = 8'(words); ct = 16'(tiles); pp = pingpong;
        @(negedge clk_h);
        en = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_h);
    endtask

    task automatic pulse_done();
        @(negedge clk_h);
        rd_done = 1'b1;
        @(negedge clk_h);
        rd_done = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input logic [31:0] exp);
        @(negedge clk_h);
        rd_en = 1'b1; rd_addr = 7'(addr);
        @(negedge clk_h);
        rd_en = 1'b0;
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    // Producer raises vld one cycle after it sees req; optional stall bursts and one extra beat
    task automatic produce(input string tag, input int n, input logic [31:0] base,
                           input int stall_every, input int stall_len,
                           input bit hold_extra, output bit req_last);
        int sent = 0;
        int cyc = 0;
        int stall = 0;
        while (sent < n && cyc < 3000) begin
            @(negedge clk_h);
            cyc++;
            if (stall > 0) begin
                stall--;
                vld = 1'b0;
            end else if (req) begin
                vld = 1'b1;
                wdata = base + 32'(sent);
                sent++;
                if (stall_every > 0 && (sent % stall_every) == 0) stall = stall_len;
            end else begin
                vld = 1'b0;
            end
        end
        #1;
        req_last = req;
        if (hold_extra) begin
            @(negedge clk_h);
            wdata = base + 32'(n);
        end
        @(negedge clk_h);
        vld = 1'b0;
        chk({tag, "_beats"}, 64'(sent), 64'(n));
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_bank_vld", 64'(rd_bank_vld), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);

        // Single 4-beat tile, ping-pong
        pbase = pulse_total;
        load(4, 1, 1'b1);
        chk("t1_busy_run", 64'(busy), 64'd1);
        produce("t1", 4, 32'h0000_0100, 0, 0, 1'b0, rq_last);
        chk("t1_req_last", 64'(rq_last), 64'd0);
        wait_cyc(2);
        chk("t1_pulses", 64'(pulse_total - pbase), 64'd1);
        chk("t1_bank_vld", 64'(rd_bank_vld), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_req_idle", 64'(req), 64'd0);
        for (int i = 0; i < 4; i++) rd("t1_rd", i, 32'h0000_0100 + 32'(i));
        pulse_done();
        #1;
        chk("t1_released", 64'(rd_bank_vld), 64'd0);

        // Three 27-beat tiles with a stalled consumer
        do_reset();
        pbase = pulse_total;
        load(27, 3, 1'b1);
        produce("t2a", 27, 32'h0000_1000, 0, 0, 1'b0, rq_last);
        produce("t2b", 27, 32'h0000_2000, 0, 0, 1'b0, rq_last);
        wait_cyc(5);
        chk("t2_wait_req", 64'(req), 64'd0);
        chk("t2_wait_busy", 64'(busy), 64'd1);
        chk("t2_wait_pulses", 64'(pulse_total - pbase), 64'd2);
        rd("t2_b0_first", 0, 32'h0000_1000);
        rd("t2_b0_last", 26, 32'h0000_101a);
        pulse_done();
        produce("t2c", 27, 32'h0000_3000, 0, 0, 1'b0, rq_last);
        wait_cyc(2);
        chk("t2_pulses", 64'(pulse_total - pbase), 64'd3);
        chk("t2_busy_end", 64'(busy), 64'd0);
        chk("t2_b1_vld", 64'(rd_bank_vld), 64'd1);
        rd("t2_b1", 5, 32'h0000_2005);
        pulse_done();
        #1;
        chk("t2_b0_vld", 64'(rd_bank_vld), 64'd1);
        rd("t2_b0_tile2", 26, 32'h0000_301a);
        pulse_done();
        #1;
        chk("t2_all_free", 64'(rd_bank_vld), 64'd0);
        chk("t2_err", 64'(err), 64'd0);

        // 120 beats with 5-cycle stalls every 27 beats
        do_reset();
        load(120, 1, 1'b1);
        produce("t3", 120, 32'h0000_a000, 27, 5, 1'b0, rq_last);
        wait_cyc(2);
        chk("t3_bank_vld", 64'(rd_bank_vld), 64'd1);
        for (int i = 0; i < 120; i++) rd("t3_rd", i, 32'h0000_a000 + 32'(i));

        // Overflow beat after the final one, then a spurious release
        do_reset();
        load(4, 1, 1'b1);
        produce("t4", 4, 32'h0000_0400, 0, 0, 1'b1, rq_last);
        wait_cyc(1);
        chk("t4_ovf_err", 64'(err), 64'd1);
        rd("t4_last_beat", 3, 32'h0000_0403);
        pulse_done();
        pulse_done();
        #1;
        chk("t4_udf_err", 64'(err), 64'd1);
        chk("t4_udf_vld", 64'(rd_bank_vld), 64'd0);
        load(4, 1, 1'b1);
        produce("t4b", 4, 32'h0000_e000, 0, 0, 1'b0, rq_last);
        wait_cyc(2);
        chk("t4_b1_vld", 64'(rd_bank_vld), 64'd1);
        rd("t4_b1", 2, 32'h0000_e002);

        // Invalid configuration
        do_reset();
        load(0, 1, 1'b1);
        wait_cyc(1);
        chk("t5_cfg_err", 64'(err), 64'd2);
        chk("t5_cfg_busy", 64'(busy), 64'd0);
        chk("t5_cfg_req", 64'(req), 64'd0);

        // Full-depth tiles on a single bank
        do_reset();
        pbase = pulse_total;
        load(128, 2, 1'b0);
        produce("t5a", 128, 32'h0000_b000, 0, 0, 1'b0, rq_last);
        wait_cyc(3);
        chk("t5_wait_req", 64'(req), 64'd0);
        chk("t5_wait_busy", 64'(busy), 64'd1);
        chk("t5_wait_vld", 64'(rd_bank_vld), 64'd1);
        rd("t5_b0_last", 127, 32'h0000_b07f);
        pulse_done();
        #1;
        chk("t5_released", 64'(rd_bank_vld), 64'd0);
        produce("t5b", 128, 32'h0000_c000, 0, 0, 1'b0, rq_last);
        wait_cyc(2);
        chk("t5_busy_end", 64'(busy), 64'd0);
        chk("t5_pulses", 64'(pulse_total - pbase), 64'd2);
        chk("t5_b0_vld", 64'(rd_bank_vld), 64'd1);
        rd("t5_b0_tile2", 0, 32'h0000_c000);
        chk("t5_err", 64'(err), 64'd0);

        // Reset in the middle of a tile
        do_reset();
        load(27, 1, 1'b1);
        produce("t6", 10, 32'h0000_d000, 0, 0, 1'b0, rq_last);
        rd("t6_pre_rst", 3, 32'h0000_d003);
        pbase = pulse_total;
        @(negedge clk_h);
        rst_n = 1'b0;
        @(negedge clk_h);
        rst_n = 1'b1;
        #1;
        chk("t6_req", 64'(req), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_vld", 64'(rd_bank_vld), 64'd0);
        chk("t6_sblk", 64'(sblk), 64'd0);
        chk("t6_rd_data", 64'(rd_data), 64'd0);
        wait_cyc(30);
        chk("t6_no_pulse", 64'(pulse_total - pbase), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
